// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants and FSM state encoding for the data memory
//                responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int unsigned c_lane_w   = 8;
    localparam int unsigned c_lanes    = 4;
    localparam int unsigned c_max_wait = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : Request/response bundle between the LSU and the data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        ready;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wmask, wdata,
        input  ready, stall, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wmask, wdata,
        output ready, stall, ack, rdata, err
    );

endinterface
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_byte_ram
//  Description : Byte-laned synchronous RAM, per-lane write enable and a
//                registered read port. Storage is never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                          clk,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [c_lanes-1:0]            i_we,
    input  logic                          i_re,
    input  logic [c_lanes*c_lane_w-1:0]   i_wdata,
    output logic [c_lanes*c_lane_w-1:0]   o_rdata
);

    for (genvar k = 0; k < c_lanes; k++) begin : g_lane
        logic [c_lane_w-1:0] r_mem [DEPTH_WORDS];
        logic [c_lane_w-1:0] r_q;

        always_ff @(posedge clk) begin
            if (i_we[k]) begin
                r_mem[i_addr] <= i_wdata[k*c_lane_w +: c_lane_w];
            end
            if (i_re) begin
                r_q <= r_mem[i_addr];
            end
        end

        assign o_rdata[k*c_lane_w +: c_lane_w] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Memory-side responder for the RV32I data port: byte-masked
//                writes / full-word reads with configurable wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned c_aw   = $clog2(DEPTH_WORDS);
    localparam int unsigned c_cw   = $clog2(c_max_wait + 1);
    localparam logic [32:0] c_span = 33'(DEPTH_WORDS) << 2;
    localparam logic [c_cw-1:0] c_one = c_cw'(1);

    dmem_state_e     r_state;
    dmem_state_e     w_next;
    logic [c_cw-1:0] r_wcnt;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_wmask;
    logic [31:0]     r_wdata;
    logic            r_rd_ok;
    logic            r_err;

    logic            w_ready;
    logic            w_accept;
    logic            w_sel_cap;
    logic            w_we;
    logic [31:0]     w_addr;
    logic [3:0]      w_wmask;
    logic [31:0]     w_wdata;
    logic [31:0]     w_off;
    logic            w_bad;
    logic            w_commit;
    logic [31:0]     w_ram_q;

    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_accept = bus.req && w_ready;

    // Without wait states the commit edge is the acceptance edge itself, so
    // the RAM must see the live request rather than the captured copy.
    assign w_sel_cap = (r_state == ST_WAIT);
    assign w_we      = w_sel_cap ? r_we    : bus.we;
    assign w_addr    = w_sel_cap ? r_addr  : bus.addr;
    assign w_wmask   = w_sel_cap ? r_wmask : bus.wmask;
    assign w_wdata   = w_sel_cap ? r_wdata : bus.wdata;

    assign w_off    = w_addr - BASE_ADDR;
    assign w_bad    = (w_addr[1:0] != 2'b00) || ({1'b0, w_off} >= c_span);
    assign w_commit = (w_next == ST_RESP) && (w_sel_cap || w_accept);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wcnt == c_one) begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wmask <= '0;
            r_wdata <= '0;
            r_rd_ok <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wcnt  <= c_cw'(WAIT_STATES);
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_wmask <= bus.wmask;
                r_wdata <= bus.wdata;
            end else if (r_state == ST_WAIT) begin
                r_wcnt  <= r_wcnt - c_one;
            end
            r_rd_ok <= w_commit && !w_we && !w_bad;
            r_err   <= w_commit && w_bad;
        end
    end

    dmem_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_off[c_aw+1:2]),
        .i_we    ({c_lanes{w_commit && w_we && !w_bad}} & w_wmask),
        .i_re    (w_commit && !w_we && !w_bad),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_q)
    );

    assign bus.ready = w_ready;
    assign bus.stall = (r_state == ST_WAIT);
    assign bus.ack   = (r_state == ST_RESP);
    assign bus.rdata = r_rd_ok ? w_ram_q : 32'h0;
    assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed bench: one responder with no wait states, one with
//                three wait states and a non-zero base address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst0_n;
    logic rst3_n;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder_if b0 ();
    data_mem_responder_if b3 ();

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (0),
        .BASE_ADDR   (32'h0000_0000)
    ) u_dut0 (
        .clk     (clk),
        .reset_n (rst0_n),
        .bus     (b0.slave)
    );

    data_mem_responder #(
        .DEPTH_WORDS (64),
        .WAIT_STATES (3),
        .BASE_ADDR   (32'h0000_1000)
    ) u_dut3 (
        .clk     (clk),
        .reset_n (rst3_n),
        .bus     (b3.slave)
    );

    always @(posedge clk) begin
        assert (!(b0.stall && b0.req) && !(b3.stall && b3.req))
            else $error("FAIL req_in_wait: request raised while stalled");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc0(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
        b0.req = 1'b1; b0.we = w; b0.addr = a; b0.wmask = m; b0.wdata = d;
        check({tag, "_ready"}, 32'(b0.ready), 32'd1);
        tick();
        b0.req = 1'b0;
        check({tag, "_ack"},   32'(b0.ack), 32'd1);
        check({tag, "_err"},   32'(b0.err), 32'(exp_err));
        check({tag, "_rdata"}, b0.rdata, exp_rd);
        tick();
        check({tag, "_ack_off"}, 32'(b0.ack), 32'd0);
    endtask

    task automatic acc3(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
        b3.req = 1'b1; b3.we = w; b3.addr = a; b3.wmask = m; b3.wdata = d;
        check({tag, "_ready"}, 32'(b3.ready), 32'd1);
        tick();
        b3.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_wait_st"}, {29'd0, b3.stall, b3.ready, b3.ack}, 32'b100);
            tick();
        end
        check({tag, "_ack_st"}, {29'd0, b3.stall, b3.ready, b3.ack}, 32'b011);
        check({tag, "_err"},    32'(b3.err), 32'(exp_err));
        check({tag, "_rdata"},  b3.rdata, exp_rd);
        tick();
        check({tag, "_ack_off"}, 32'(b3.ack), 32'd0);
    endtask

    initial begin
        rst0_n = 1'b1; rst3_n = 1'b1;
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wmask = '0; b0.wdata = '0;
        b3.req = 1'b0; b3.we = 1'b0; b3.addr = '0; b3.wmask = '0; b3.wdata = '0;
        #1;
        rst0_n = 1'b0; rst3_n = 1'b0;
        #2;
        check("rst0_out", {27'd0, b0.ready, b0.stall, b0.ack, b0.err, |b0.rdata}, 32'b10000);
        check("rst3_out", {27'd0, b3.ready, b3.stall, b3.ack, b3.err, |b3.rdata}, 32'b10000);
        tick();
        tick();
        rst0_n = 1'b1; rst3_n = 1'b1;
        tick();

        // Full-word write and read-back, no wait states
        acc0("t1_wr", 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        acc0("t1_rd", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Single-lane update
        acc0("t2_wr", 1'b1, 32'h20, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
        acc0("t2_wb", 1'b1, 32'h20, 4'b0100, 32'h00AA_0000, 32'h0, 1'b0);
        acc0("t2_rd", 1'b0, 32'h20, 4'h0, 32'h0, 32'h11AA_3344, 1'b0);

        // Split beats served back-to-back
        acc0("t3_pre0", 1'b1, 32'h30, 4'hF, 32'h0102_0304, 32'h0, 1'b0);
        acc0("t3_pre1", 1'b1, 32'h34, 4'hF, 32'hA0B0_C0D0, 32'h0, 1'b0);
        b0.req = 1'b1; b0.we = 1'b1; b0.addr = 32'h30; b0.wmask = 4'b1000; b0.wdata = 32'h5500_0000;
        tick();
        check("t3_b0_ack", {30'd0, b0.ack, b0.ready}, 32'b11);
        b0.addr = 32'h34; b0.wmask = 4'b0111; b0.wdata = 32'h0066_5544;
        tick();
        b0.req = 1'b0;
        check("t3_b1_ack", {30'd0, b0.ack, b0.err}, 32'b10);
        tick();
        check("t3_idle", 32'(b0.ack), 32'd0);
        acc0("t3_rd0", 1'b0, 32'h30, 4'h0, 32'h0, 32'h5502_0304, 1'b0);
        acc0("t3_rd1", 1'b0, 32'h34, 4'h0, 32'h0, 32'hA066_5544, 1'b0);

        // Empty mask acks without touching memory
        acc0("t2_m0", 1'b1, 32'h10, 4'h0, 32'h1234_5678, 32'h0, 1'b0);
        acc0("t2_m0rd", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Error cases
        acc0("t5_pre", 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        acc0("t5_mis_rd", 1'b0, 32'h2, 4'h0, 32'h0, 32'h0, 1'b1);
        acc0("t5_oor_wr", 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        acc0("t5_oor_chk", 1'b0, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        acc0("t5_mis_wr", 1'b1, 32'h12, 4'hF, 32'h0, 32'h0, 1'b1);
        acc0("t5_mis_chk", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Three wait states, offset base
        acc3("t4_wr", 1'b1, 32'h1008, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        acc3("t4_rd", 1'b0, 32'h1008, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
        acc3("t4_low", 1'b0, 32'h0008, 4'h0, 32'h0, 32'h0, 1'b1);
        acc3("t4_oor", 1'b0, 32'h1100, 4'h0, 32'h0, 32'h0, 1'b1);

        // Reset during the wait of a write drops it
        acc3("t6_pre", 1'b1, 32'h1010, 4'hF, 32'h0BAD_CAFE, 32'h0, 1'b0);
        b3.req = 1'b1; b3.we = 1'b1; b3.addr = 32'h1010; b3.wmask = 4'hF; b3.wdata = 32'hFFFF_FFFF;
        tick();
        b3.req = 1'b0;
        tick();
        check("t6_in_wait", 32'(b3.stall), 32'd1);
        rst3_n = 1'b0;
        #1;
        check("t6_rst_out", {28'd0, b3.ready, b3.stall, b3.ack, b3.err}, 32'b1000);
        tick();
        tick();
        rst3_n = 1'b1;
        tick();
        acc3("t6_rd", 1'b0, 32'h1010, 4'h0, 32'h0, 32'h0BAD_CAFE, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
